// File: rtl/mem_arbiter.sv
// Three-port arbiter (fetch, data, loader) in front of one single-port synchronous RAM.
// Fixed D > I > X priority, with anti-starvation promotion of I and X.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,

    input  logic              x_req_i,
    input  logic              x_we_i,
    input  logic [ADDR_W-1:0] x_addr_i,
    input  logic [31:0]       x_wdata_i,
    output logic              x_gnt_o,
    output logic              x_rvalid_o,

    output logic [31:0]       rdata_o,

    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] i_starve_q, i_starve_d;
    logic [CntW-1:0] x_starve_q, x_starve_d;
    // Pending read owner, one-hot {d, i, x}
    logic [2:0]      pend_q, pend_d;

    always_comb begin
        i_gnt_o = 1'b0;
        d_gnt_o = 1'b0;
        x_gnt_o = 1'b0;
        if (rst_n) begin
            if (x_req_i && (x_starve_q == CntMax)) begin
                x_gnt_o = 1'b1;
            end else if (i_req_i && (i_starve_q == CntMax)) begin
                i_gnt_o = 1'b1;
            end else if (d_req_i) begin
                d_gnt_o = 1'b1;
            end else if (i_req_i) begin
                i_gnt_o = 1'b1;
            end else if (x_req_i) begin
                x_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en_o    = i_gnt_o | d_gnt_o | x_gnt_o;
        mem_we_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (d_gnt_o) begin
            mem_addr_o  = d_addr_i[ADDR_W-1:2];
            mem_wdata_o = d_wdata_i;
            mem_we_o    = d_we_i ? d_be_i : 4'b0000;
        end else if (i_gnt_o) begin
            mem_addr_o  = i_addr_i[ADDR_W-1:2];
        end else if (x_gnt_o) begin
            mem_addr_o  = x_addr_i[ADDR_W-1:2];
            mem_wdata_o = x_wdata_i;
            mem_we_o    = x_we_i ? 4'b1111 : 4'b0000;
        end
    end

    always_comb begin
        i_starve_d = '0;
        x_starve_d = '0;
        if (i_req_i && !i_gnt_o) begin
            i_starve_d = (i_starve_q == CntMax) ? CntMax : i_starve_q + 1'b1;
        end
        if (x_req_i && !x_gnt_o) begin
            x_starve_d = (x_starve_q == CntMax) ? CntMax : x_starve_q + 1'b1;
        end
        pend_d = {d_gnt_o & ~d_we_i, i_gnt_o, x_gnt_o & ~x_we_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_starve_q <= '0;
            x_starve_q <= '0;
            pend_q     <= 3'b000;
        end else begin
            i_starve_q <= i_starve_d;
            x_starve_q <= x_starve_d;
            pend_q     <= pend_d;
        end
    end

    // Masking with rst_n kills a read issued just before reset was asserted
    assign d_rvalid_o = pend_q[2] & rst_n;
    assign i_rvalid_o = pend_q[1] & rst_n;
    assign x_rvalid_o = pend_q[0] & rst_n;
    assign rdata_o    = mem_rdata_i;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32: byte-address width of all requester ports.
REQ-002 The block SHALL take parameter STARVE_MAX, default 4: consecutive denied cycles after which a lower-priority requester is promoted.
REQ-003 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_req_i  input  1  instruction-fetch read request.
- i_addr_i  input  ADDR_W  fetch byte address.
- i_gnt_o  output  1  fetch request accepted this cycle.
- i_rvalid_o  output  1  fetch read data valid on rdata_o.
- d_req_i  input  1  CPU data request.
- d_we_i  input  1  data write (1) / read (0).
- d_be_i  input  4  data write byte enables.
- d_addr_i  input  ADDR_W  data byte address.
- d_wdata_i  input  32  data write word.
- d_gnt_o  output  1  data request accepted this cycle.
- d_rvalid_o  output  1  data read data valid on rdata_o.
- x_req_i  input  1  external loader/debug request.
- x_we_i  input  1  loader write (1) / read (0).
- x_addr_i  input  ADDR_W  loader byte address.
- x_wdata_i  input  32  loader write word.
- x_gnt_o  output  1  loader request accepted this cycle.
- x_rvalid_o  output  1  loader read data valid on rdata_o.
- rdata_o  output  32  shared read data, equal to mem_rdata_i.
- mem_en_o  output  1  memory access enable.
- mem_we_o  output  4  memory byte write enables.
- mem_addr_o  output  ADDR_W-2  memory word address.
- mem_wdata_o  output  32  memory write word.
- mem_rdata_i  input  32  memory read word, valid one cycle after a read access.

Function
REQ-004 The block SHALL shares one single-port synchronous RAM (1-cycle read latency) among requesters I, D, X, with at most one grant per cycle.
REQ-005 Grants SHALL be combinational from the current requests and registered state; a request is accepted in the cycle its gnt is high; gnt is never high without its req.
REQ-006 Priority SHALL be: X if x_starve == STARVE_MAX; else I if i_starve == STARVE_MAX; else fixed D > I > X.
REQ-007 Each of i_starve and x_starve SHALL be a counter that increments (saturating at STARVE_MAX) each cycle its port requests and is denied, and clears to 0 on grant or on req low.
REQ-008 When both counters equal STARVE_MAX, X SHALL win; I SHALL then win the following cycle if still requesting.
REQ-009 On any grant, mem_en_o=1 and mem_addr_o SHALL equal the granted address bits [ADDR_W-1:2]; address bits [1:0] are ignored.
REQ-010 mem_we_o SHALL be 4'b0000 for I and for reads, d_be_i for D writes, and 4'b1111 for X writes; mem_wdata_o SHALL carry the granted port's write data (don't-care otherwise).
REQ-011 With no grant, mem_en_o=0 and mem_we_o=0.
REQ-012 A read granted in cycle t SHALL raise exactly that port's rvalid for one cycle at t+1; writes SHALL produce no rvalid.
REQ-013 At most one rvalid SHALL be high in any cycle; back-to-back reads from any ports are accepted every cycle with no bubbles.
REQ-014 A D write with d_be_i=0 SHALL be granted normally and drive mem_we_o=0 (no memory change, no rvalid).

Reset
REQ-015 While rst_n=0 at a clock edge, i_starve, x_starve and the pending-read register SHALL clear; all gnt outputs, mem_en_o and mem_we_o SHALL be 0 while rst_n=0.
REQ-016 A read granted in the cycle before reset is applied SHALL NOT produce rvalid after reset; all rvalid outputs SHALL be 0 in the first cycle after rst_n rises.

Verification
REQ-017 D read d_addr_i=0x0000_0010 alone at cycle t -> d_gnt_o=1, mem_en_o=1, mem_we_o=0, mem_addr_o=0x4 at t; d_rvalid_o=1 and rdata_o=mem_rdata_i at t+1.
REQ-018 D write d_be_i=4'b0011, d_wdata_i=0xDEADBEEF, with I also requesting -> d_gnt_o=1, mem_we_o=4'b0011, i_gnt_o=0, no rvalid next cycle.
REQ-019 D and I requesting continuously from cycle 0 -> D granted cycles 0-3, I granted cycle 4, D granted cycles 5-8, I granted cycle 9.
REQ-020 I, D, X all requesting continuously -> X granted at cycle 4, I granted at cycle 5 (both counters saturated), then D resumes at cycle 6.
REQ-021 X write x_addr_i=0x100 -> mem_we_o=4'b1111, mem_addr_o=0x40; alternating I/X reads every cycle -> one rvalid per cycle to the matching port.
REQ-022 Grant I read at t, assert rst_n=0 at t+1 -> i_rvalid_o=0 and all gnt=0 while in reset; counters read 0 after release.
